// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its load-use detector.
package id_ex_stage_reg_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned EX_W_DEFAULT = 4;
  localparam int unsigned REG_W        = 5;

  // Bit positions inside the WB and MEM control pairs
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned M_MEMREAD   = 1;
  localparam int unsigned M_MEMWRITE  = 0;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard check: decode reads a register an in-flight EX load will write.
module id_ex_stage_reg_load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             haz_c
);

  // Both sources are compared whatever the instruction format; x0 never hazards
  assign haz_c = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and external hold.
// Optional macro ID_EX_PERF_CNT_EN adds stall/flush event counters.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned EX_W = EX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic [1:0]       id_wb,
  input  logic [1:0]       id_m,
  input  logic [EX_W-1:0]  id_ex,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             ID_EX_valid,
  output logic [REG_W-1:0] ID_EX_rs1,
  output logic [REG_W-1:0] ID_EX_rs2,
  output logic [REG_W-1:0] ID_EX_rd,
  output logic [1:0]       ID_EX_wb,
  output logic [1:0]       ID_EX_m,
  output logic [EX_W-1:0]  ID_EX_ex,
  output logic [XLEN-1:0]  ID_EX_pc,
  output logic [XLEN-1:0]  ID_EX_rdata1,
  output logic [XLEN-1:0]  ID_EX_rdata2,
  output logic [XLEN-1:0]  ID_EX_imm,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             load_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  state_t state;
  state_t state_nxt;
  logic   haz_c;
  logic   bubble;

  id_ex_stage_reg_load_use_detect u_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ID_EX_valid),
    .ex_mem_read (ID_EX_m[M_MEMREAD]),
    .ex_rd       (ID_EX_rd),
    .haz_c       (haz_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // In BUBBLE the register already holds a non-load, so the hazard is not re-raised
  always_comb begin
    state_nxt  = state;
    load_stall = 1'b0;
    case (state)
      RUN: begin
        load_stall = haz_c && !flush;
        if (haz_c && !flush && !ext_stall) begin
          state_nxt = BUBBLE;
        end
      end
      BUBBLE: begin
        if (flush || !ext_stall) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign pc_write    = !(load_stall || ext_stall);
  assign if_id_write = pc_write;

  // Reset, flush and an unheld load-use all leave an all-zero bubble in EX
  assign bubble = !rst_n || flush || (!ext_stall && load_stall);

  always_ff @(posedge clk) begin
    if (bubble) begin
      ID_EX_valid  <= 1'b0;
      ID_EX_rs1    <= '0;
      ID_EX_rs2    <= '0;
      ID_EX_rd     <= '0;
      ID_EX_wb     <= '0;
      ID_EX_m      <= '0;
      ID_EX_ex     <= '0;
      ID_EX_pc     <= '0;
      ID_EX_rdata1 <= '0;
      ID_EX_rdata2 <= '0;
      ID_EX_imm    <= '0;
    end else if (!ext_stall) begin
      ID_EX_valid  <= id_valid;
      ID_EX_rs1    <= id_rs1;
      ID_EX_rs2    <= id_rs2;
      ID_EX_rd     <= id_rd;
      ID_EX_wb     <= id_wb;
      ID_EX_m      <= id_m;
      ID_EX_ex     <= id_ex;
      ID_EX_pc     <= id_pc;
      ID_EX_rdata1 <= id_rdata1;
      ID_EX_rdata2 <= id_rdata2;
      ID_EX_imm    <= id_imm;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (load_stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed test-plan sequences plus random traffic.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned EX_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, id_valid, flush, ext_stall;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [1:0]      id_wb, id_m;
  logic [EX_W-1:0] id_ex;
  logic [XLEN-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic            ID_EX_valid;
  logic [4:0]      ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [1:0]      ID_EX_wb, ID_EX_m;
  logic [EX_W-1:0] ID_EX_ex;
  logic [XLEN-1:0] ID_EX_pc, ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm;
  logic            pc_write, if_id_write, load_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt, perf_flush_cnt;
`endif

  id_ex_stage_reg #(.XLEN(XLEN), .EX_W(EX_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_pc(id_pc),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .flush(flush), .ext_stall(ext_stall),
    .ID_EX_valid(ID_EX_valid), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_wb(ID_EX_wb), .ID_EX_m(ID_EX_m), .ID_EX_ex(ID_EX_ex),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2),
    .ID_EX_imm(ID_EX_imm), .pc_write(pc_write), .if_id_write(if_id_write),
    .load_stall(load_stall)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct {
    logic            rst_n, id_valid, flush, ext_stall;
    logic [4:0]      rs1, rs2, rd;
    logic [1:0]      wb, m;
    logic [EX_W-1:0] ex;
    logic [XLEN-1:0] pc, rd1, rd2, imm;
  } stim_t;

  // Contents the EX stage should hold, plus the front-end controls seen before the edge
  typedef struct {
    bit              chk_comb;
    logic            ls, pw;
    logic            valid;
    logic [4:0]      rs1, rs2, rd;
    logic [1:0]      wb, m;
    logic [EX_W-1:0] ex;
    logic [XLEN-1:0] pc, rd1, rd2, imm;
    logic [31:0]     sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t mdl;
  bit   known;
  bit   stalled_last;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{rst_n: 1'b1, id_valid: 1'b0, flush: 1'b0, ext_stall: 1'b0,
          rs1: 5'd0, rs2: 5'd0, rd: 5'd0, wb: 2'd0, m: 2'd0, ex: '0,
          pc: '0, rd1: '0, rd2: '0, imm: '0};
    return s;
  endfunction

  function automatic stim_t instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic [1:0] wb,
                                  input logic [1:0] m, input logic [31:0] pc);
    stim_t s;
    s = nop();
    s.id_valid = 1'b1;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.wb = wb; s.m = m; s.pc = pc;
    s.ex  = EX_W'($urandom);
    s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom), 2'($urandom), $urandom);
    s.rst_n     = ($urandom_range(0, 49) != 0);
    s.id_valid  = ($urandom_range(0, 5) != 0);
    s.flush     = ($urandom_range(0, 9) == 0);
    s.ext_stall = ($urandom_range(0, 6) == 0);
    return s;
  endfunction

  // Apply one cycle of stimulus and queue what the pipeline should do with it
  task automatic drive(input stim_t s);
    exp_t e;
    logic haz, ls;
    @(negedge clk);
    rst_n = s.rst_n; id_valid = s.id_valid; flush = s.flush; ext_stall = s.ext_stall;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_wb = s.wb; id_m = s.m; id_ex = s.ex;
    id_pc = s.pc; id_rdata1 = s.rd1; id_rdata2 = s.rd2; id_imm = s.imm;

    // A load in EX whose destination decode reads forces one bubble, once per load
    haz = s.id_valid && mdl.valid && mdl.m[M_MEMREAD] && (mdl.rd != 5'd0) &&
          ((mdl.rd == s.rs1) || (mdl.rd == s.rs2));
    ls  = haz && !stalled_last && !s.flush;

    e = mdl;
    e.chk_comb = known;
    e.ls = ls;
    e.pw = !(ls || s.ext_stall);

    if (!s.rst_n || s.flush || (!s.ext_stall && ls)) begin
      mdl.valid = 0; mdl.rs1 = 0; mdl.rs2 = 0; mdl.rd = 0; mdl.wb = 0; mdl.m = 0;
      mdl.ex = 0; mdl.pc = 0; mdl.rd1 = 0; mdl.rd2 = 0; mdl.imm = 0;
      stalled_last = s.rst_n && !s.flush && ls;
    end else if (!s.ext_stall) begin
      mdl.valid = s.id_valid; mdl.rs1 = s.rs1; mdl.rs2 = s.rs2; mdl.rd = s.rd;
      mdl.wb = s.wb; mdl.m = s.m; mdl.ex = s.ex; mdl.pc = s.pc;
      mdl.rd1 = s.rd1; mdl.rd2 = s.rd2; mdl.imm = s.imm;
      stalled_last = 1'b0;
    end
    if (!s.rst_n) begin
      mdl.sc = 0; mdl.fc = 0;
    end else begin
      mdl.sc = mdl.sc + 32'(ls);
      mdl.fc = mdl.fc + 32'(s.flush);
    end
    if (!s.rst_n) known = 1'b1;

    e.valid = mdl.valid; e.rs1 = mdl.rs1; e.rs2 = mdl.rs2; e.rd = mdl.rd;
    e.wb = mdl.wb; e.m = mdl.m; e.ex = mdl.ex; e.pc = mdl.pc;
    e.rd1 = mdl.rd1; e.rd2 = mdl.rd2; e.imm = mdl.imm;
    e.sc = mdl.sc; e.fc = mdl.fc;
    q.push_back(e);
  endtask

  // Monitor: front-end controls mid-cycle, then the registered EX contents after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q[0];
        if (e.chk_comb) begin
          chk("load_stall", 128'(load_stall), 128'(e.ls));
          chk("pc_write", 128'(pc_write), 128'(e.pw));
          chk("if_id_write", 128'(if_id_write), 128'(e.pw));
        end
        @(posedge clk);
        #1;
        chk("ID_EX_valid", 128'(ID_EX_valid), 128'(e.valid));
        chk("ID_EX_ctrl", 128'({ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_wb, ID_EX_m, ID_EX_ex}),
            128'({e.rs1, e.rs2, e.rd, e.wb, e.m, e.ex}));
        chk("ID_EX_data", {ID_EX_pc, ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm},
            {e.pc, e.rd1, e.rd2, e.imm});
`ifdef ID_EX_PERF_CNT_EN
        chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'(e.sc));
        chk("perf_flush_cnt", 128'(perf_flush_cnt), 128'(e.fc));
`endif
        void'(q.pop_front());
      end
    end
  end

  initial begin
    stim_t s;
    mdl = '{default: '0};
    known = 1'b0;
    stalled_last = 1'b0;
    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_wb = '0; id_m = '0; id_ex = '0;
    id_pc = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;

    s = nop(); s.rst_n = 1'b0;
    drive(s);
    drive(s);

    // lw x5 then add x6,x5,x7: one bubble, then the add enters EX
    drive(instr(5'd1, 5'd0, 5'd5, 2'b11, 2'b10, 32'h40));
    drive(instr(5'd5, 5'd7, 5'd6, 2'b10, 2'b00, 32'h44));
    drive(instr(5'd5, 5'd7, 5'd6, 2'b10, 2'b00, 32'h44));

    // lw x0 followed by a reader of x0: no stall
    drive(instr(5'd1, 5'd0, 5'd0, 2'b11, 2'b10, 32'h48));
    drive(instr(5'd3, 5'd0, 5'd4, 2'b10, 2'b00, 32'h4c));

    // Hazard coinciding with flush: flush wins
    drive(instr(5'd1, 5'd0, 5'd5, 2'b11, 2'b10, 32'h50));
    s = instr(5'd5, 5'd7, 5'd6, 2'b10, 2'b00, 32'h54); s.flush = 1'b1;
    drive(s);
    drive(instr(5'd5, 5'd7, 5'd6, 2'b10, 2'b00, 32'h58));

    // External hold over three cycles
    drive(instr(5'd2, 5'd3, 5'd4, 2'b10, 2'b00, 32'h100));
    for (int i = 0; i < 3; i++) begin
      s = instr(5'd2, 5'd3, 5'd4, 2'b10, 2'b00, 32'h104); s.ext_stall = 1'b1;
      drive(s);
    end
    drive(instr(5'd2, 5'd3, 5'd4, 2'b10, 2'b00, 32'h104));

    // Reset while the bubble is in flight, then back-to-back loads
    drive(instr(5'd1, 5'd0, 5'd5, 2'b11, 2'b10, 32'h200));
    drive(instr(5'd5, 5'd7, 5'd6, 2'b10, 2'b00, 32'h204));
    s = instr(5'd5, 5'd7, 5'd6, 2'b10, 2'b00, 32'h204); s.rst_n = 1'b0;
    drive(s);
    drive(instr(5'd1, 5'd0, 5'd5, 2'b11, 2'b10, 32'h300));
    drive(instr(5'd2, 5'd0, 5'd6, 2'b11, 2'b10, 32'h304));
    drive(instr(5'd6, 5'd5, 5'd7, 2'b10, 2'b00, 32'h308));
    drive(instr(5'd6, 5'd5, 5'd7, 2'b10, 2'b00, 32'h308));

    for (int i = 0; i < 400; i++) begin
      drive(rand_stim());
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
    end
    chk("scoreboard_drain", 128'(q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
